// File: rtl/cc_deserializer_pkg.sv
// Shared cache-controller definitions: R-channel/line geometry and the
// line-transfer FSM state encoding used by the serializer and deserializer.
package cc_deserializer_pkg;

    localparam int CC_DATA_W   = 64;
    localparam int CC_BEATS    = 8;
    localparam int CC_OFFSET_W = 6;
    localparam int CC_LINE_W   = CC_DATA_W * CC_BEATS;
    localparam int CC_ENTRY_W  = CC_OFFSET_W + CC_LINE_W;

    typedef enum logic [1:0] {
        CC_IDLE    = 2'd0,
        CC_COLLECT = 2'd1,
        CC_WRITE   = 2'd2
    } cc_state_e;

endpackage

// File: rtl/cc_deserializer.sv
// Collects eight critical-word-first R-channel beats into a 512-bit line and
// pushes {offset, line} into the line FIFO with a single write strobe.
module cc_deserializer
    import cc_deserializer_pkg::*;
#(
    parameter int DATA_W   = CC_DATA_W,
    parameter int BEATS    = CC_BEATS,
    parameter int OFFSET_W = CC_OFFSET_W
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid_i,
    input  logic [OFFSET_W-1:0]                 req_offset_i,
    output logic                                req_ready_o,
    input  logic [DATA_W-1:0]                   rdata_i,
    input  logic                                rlast_i,
    input  logic                                rvalid_i,
    output logic                                rready_o,
    input  logic                                fifo_full_i,
    input  logic                                fifo_afull_i,
    output logic                                fifo_wren_o,
    output logic [OFFSET_W+BEATS*DATA_W-1:0]    fifo_wdata_o,
    output logic                                err_o
);

    localparam int               IDX_W     = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

    cc_state_e                       state_r;
    logic                            req_ready_r;
    logic                            rready_r;
    logic                            err_r;
    logic [OFFSET_W-1:0]             offset_r;
    logic [IDX_W-1:0]                cnt_r;
    logic [BEATS-1:0][DATA_W-1:0]    line_r;

    logic                            xfer_s;
    logic                            is_last_s;
    logic [IDX_W-1:0]                idx_s;
    logic [BEATS-1:0]                we_s;
    logic                            unused_s;

    assign xfer_s    = rvalid_i && rready_r;
    assign is_last_s = (cnt_r == LAST_BEAT);
    // Word index wraps naturally in IDX_W bits, giving critical-word-first order.
    assign idx_s     = offset_r[OFFSET_W-1 -: IDX_W] + cnt_r;
    assign unused_s  = fifo_afull_i;

    // Decode the line-buffer word enable for the current beat transfer.
    always_comb begin
        we_s = {BEATS{1'b0}};
        for (int i = 0; i < BEATS; i++) begin
            if (xfer_s && (idx_s == IDX_W'(i))) begin
                we_s[i] = 1'b1;
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    // Fill-sequencing FSM with registered handshake flags and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= CC_IDLE;
            req_ready_r <= 1'b1;
            rready_r    <= 1'b0;
            offset_r    <= {OFFSET_W{1'b0}};
            cnt_r       <= {IDX_W{1'b0}};
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                CC_IDLE: begin
                    if (req_valid_i) begin
                        offset_r    <= req_offset_i;
                        cnt_r       <= {IDX_W{1'b0}};
                        state_r     <= CC_COLLECT;
                        req_ready_r <= 1'b0;
                        rready_r    <= 1'b1;
                    end
                end
                CC_COLLECT: begin
                    if (xfer_s) begin
                        cnt_r <= cnt_r + IDX_W'(1);
                        // rlast must coincide exactly with the final beat.
                        if (rlast_i != is_last_s) begin
                            err_r <= 1'b1;
                        end
                        if (is_last_s) begin
                            state_r  <= CC_WRITE;
                            rready_r <= 1'b0;
                        end
                    end
                end
                CC_WRITE: begin
                    if (!fifo_full_i) begin
                        state_r     <= CC_IDLE;
                        req_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= CC_IDLE;
                    req_ready_r <= 1'b1;
                    rready_r    <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer: words persist across fills and are only overwritten by beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BEATS; i++) begin
                line_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < BEATS; i++) begin
                if (we_s[i]) begin
                    line_r[i] <= rdata_i;
                end
            end
        end
    end

    assign req_ready_o  = req_ready_r;
    assign rready_o     = rready_r;
    assign err_o        = err_r;
    assign fifo_wdata_o = {offset_r, line_r};
    // The strobe must follow fifo_full_i in the same cycle, so it is gated here.
    assign fifo_wren_o  = (state_r == CC_WRITE) && !fifo_full_i;

endmodule

// File: doc/cc_deserializer.md
CC_DESERIALIZER -- requirements
Module: cc_deserializer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning width of one R-channel beat.
REQ-002 SHALL have parameter BEATS, default 8, meaning beats per 512-bit line.
REQ-003 SHALL have parameter OFFSET_W, default 6, meaning byte-offset width of the critical word.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req_valid_i  input  1  a line fill is pending.
REQ-007 SHALL have port req_offset_i  input  6  byte offset of the critical word; bits [5:3] give the word index.
REQ-008 SHALL have port req_ready_o  output  1  the block can accept a fill request.
REQ-009 SHALL have port rdata_i  input  64  R-channel beat data.
REQ-010 SHALL have port rlast_i  input  1  R-channel last beat.
REQ-011 SHALL have port rvalid_i  input  1  R-channel beat valid.
REQ-012 SHALL have port rready_o  output  1  R-channel beat accept.
REQ-013 SHALL have port fifo_full_i  input  1  line FIFO full.
REQ-014 SHALL have port fifo_afull_i  input  1  line FIFO almost full; informational, not used for gating.
REQ-015 SHALL have port fifo_wren_o  output  1  single-cycle write strobe.
REQ-016 SHALL have port fifo_wdata_o  output  518  {offset[5:0], word7..word0}; word0 occupies bits [63:0].
REQ-017 SHALL have port err_o  output  1  sticky rlast protocol error.

Function
REQ-018 SHALL implement the FSM states IDLE, COLLECT and WRITE.
REQ-019 SHALL assert req_ready_o only in IDLE.
REQ-020 SHALL, in IDLE with req_valid_i=1, latch req_offset_i, clear the beat counter and go to COLLECT.
REQ-021 SHALL assert rready_o only in COLLECT; a beat transfers when rvalid_i && rready_o.
REQ-022 SHALL write transferred beat k (k=0..7) into word index (req_offset[5:3]+k) mod 8; the index wraps 7->0.
REQ-023 SHALL use a 3-bit beat counter that increments per transfer; the transfer with counter=7 ends collection and the FSM goes to WRITE next cycle.
REQ-024 SHALL set err_o if rlast_i=1 on a transfer with counter<7, or rlast_i=0 on the transfer with counter=7; collection still ends only at counter=7.
REQ-025 SHALL, in WRITE, drive fifo_wren_o=1 for exactly one cycle, in the first cycle with fifo_full_i=0, then go to IDLE; while fifo_full_i=1 it holds WRITE with fifo_wren_o=0 and fifo_wdata_o stable.
REQ-026 SHALL make fifo_wdata_o valid whenever fifo_wren_o=1, with the upper 6 bits equal to the latched offset.
REQ-027 SHALL give a minimum latency of 1 (request) + 8 (beats) + 1 (write) = 10 cycles from request acceptance to FIFO write, with back-to-back beats and the FIFO not full.
REQ-028 SHALL ignore rvalid_i outside COLLECT; it never accepts a beat there.
REQ-029 SHALL ignore req_valid_i outside IDLE; the request stays pending until req_ready_o.
REQ-030 SHALL keep beats not yet received this fill at their previous line-buffer contents; they are never zeroed per fill.

Reset
REQ-031 SHALL, on rst_n low (asynchronous), go to IDLE and reset the counter, latched offset and err_o to 0.
REQ-032 SHALL reset the outputs to: req_ready_o 1 once in IDLE; rready_o 0; fifo_wren_o 0; fifo_wdata_o 0.
REQ-033 SHALL, on reset mid-COLLECT or mid-WRITE, abandon the partial line and produce no FIFO write.
REQ-034 SHALL clear err_o only by reset.

Structure
REQ-035 SHALL take DATA_W, BEATS, OFFSET_W, line width 512, FIFO entry width 518 and the FSM state enum from the shared cache-controller package, which the serializer also uses.
REQ-036 SHALL have no sub-module; the line buffer is eight 64-bit registers with a decoded write enable.

Verification
REQ-037 SHALL cover: request offset 6'b011000, beats 10..17 back-to-back, rlast on the 8th beat -> after 10 cycles one wren with word3=10, word4=11, ..., word7=14, word0=15, word1=16, word2=17, upper bits 011000, err_o=0.
REQ-038 SHALL cover: offset 6'b000000, beats 0..7 with rvalid_i low every other cycle -> word i = i, wren one cycle after the 8th transfer.
REQ-039 SHALL cover: fifo_full_i=1 for 5 cycles after the 8th beat -> wren=0 for those 5 cycles with data stable, then wren=1 for exactly 1 cycle when full drops.
REQ-040 SHALL cover: rlast_i on the 5th beat -> err_o=1 and stays 1; the write still occurs after 8 beats.
REQ-041 SHALL cover: rst_n pulsed low after 4 beats -> no wren; a subsequent offset 6'b111000 fill writes word7 first, wrapping to word0.
REQ-042 SHALL cover: rvalid_i=1 while IDLE -> rready_o=0 and no beat captured.
